// File: rtl/multicycle_cu.sv
// Multicycle MIPS control unit: Moore FSM that sequences fetch, decode, execute,
// memory and write-back over a shared datapath, with cycle and retire counters.
module multicycle_cu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ERR     = 4'd15
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_retire;
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;

  // Raw strobes before gating with rst_n
  logic w_pc_write;
  logic w_pc_write_cond;
  logic w_ir_write;
  logic w_reg_write;
  logic w_mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_ERR;
        endcase
      end
      S_MEMADR: begin
        case (opcode)
          OP_LW:   w_next = S_MEMRD;
          OP_SW:   w_next = S_MEMWR;
          default: w_next = S_ERR;
        endcase
      end
      S_MEMRD: begin
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXEC:   w_next = S_RTYPEWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_mem_write     = 1'b0;
    iord            = 1'b0;
    mem_read        = 1'b0;
    mem_to_reg      = 1'b0;
    reg_dst         = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_source       = 2'b00;
    halted          = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        iord        = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RTYPEWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        w_pc_write_cond = 1'b1;
        pc_source       = 2'b01;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        pc_source  = 2'b10;
      end
      S_ERR: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  // Gating with rst_n makes an asynchronous reset kill strobes in the same cycle
  assign pc_write      = w_pc_write      & rst_n;
  assign pc_write_cond = w_pc_write_cond & rst_n;
  assign ir_write      = w_ir_write      & rst_n;
  assign reg_write     = w_reg_write     & rst_n;
  assign mem_write     = w_mem_write     & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= 32'd0;
      r_instr_count <= 32'd0;
    end else begin
      if (r_state != S_ERR) r_cycle_count <= r_cycle_count + 32'd1;
      if (w_retire)         r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign state       = r_state;
  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: directed vector table, corner-case
// sequences and randomized instruction streams against a path-level model.
module tb_multicycle_cu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg;
  logic        ir_write, reg_dst, reg_write, alu_src_a, halted;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] cycle_count, instr_count;

  multicycle_cu dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .halted(halted),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic [16:0] act_out;
  assign act_out = {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg,
                    ir_write, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, halted};

  typedef struct {
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
  } vec_t;

  vec_t tbl[$];
  vec_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected control word for a state, straight from the per-state output list
  function automatic logic [16:0] exp_out(input logic [3:0] st, input logic mr, input logic rn);
    logic pw, pwc, io, mrd, mw, m2r, irw, rd, rw, sa, hl;
    logic [1:0] sb, op, ps;
    {pw, pwc, io, mrd, mw, m2r, irw, rd, rw, sa, hl} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      4'd0:       begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      4'd1:       sb = 2'b11;
      4'd2, 4'd9: begin sa = 1; sb = 2'b10; end
      4'd3:       begin mrd = 1; io = 1; end
      4'd4:       begin rw = 1; m2r = 1; end
      4'd5:       begin mw = 1; io = 1; end
      4'd6:       begin sa = 1; op = 2'b10; end
      4'd7:       begin rw = 1; rd = 1; end
      4'd8:       begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      4'd10:      rw = 1;
      4'd11:      begin pw = 1; ps = 2'b10; end
      4'd15:      hl = 1;
      default:    ;
    endcase
    pw &= rn; pwc &= rn; irw &= rn; rw &= rn; mw &= rn;
    return {pw, pwc, io, mrd, mw, m2r, irw, rd, rw, sa, sb, op, ps, hl};
  endfunction

  task automatic drive(input logic [5:0] op, input logic mr);
    @(negedge clk);
    opcode    = op;
    mem_ready = mr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_instr", instr_count, 32'd0);
    chk("rst_outs", {15'd0, act_out}, {15'd0, exp_out(4'd0, 1'b1, 1'b0)});
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic qpush(input logic [5:0] op, input logic mr, input logic [3:0] st);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st;
    q.push_back(v);
  endtask

  // Expected state walk of one instruction, built from opcode and wait counts
  task automatic build_instr(input logic [5:0] op, input int wf, input int wm);
    q.delete();
    for (int k = 0; k < wf; k++) qpush(6'($urandom), 1'b0, 4'd0);
    qpush(6'($urandom), 1'b1, 4'd0);
    qpush(op, 1'($urandom), 4'd1);
    case (op)
      6'h23: begin
        qpush(op, 1'($urandom), 4'd2);
        for (int k = 0; k < wm; k++) qpush(6'($urandom), 1'b0, 4'd3);
        qpush(6'($urandom), 1'b1, 4'd3);
        qpush(6'($urandom), 1'($urandom), 4'd4);
      end
      6'h2B: begin
        qpush(op, 1'($urandom), 4'd2);
        for (int k = 0; k < wm; k++) qpush(6'($urandom), 1'b0, 4'd5);
        qpush(6'($urandom), 1'b1, 4'd5);
      end
      6'h00: begin
        qpush(6'($urandom), 1'($urandom), 4'd6);
        qpush(6'($urandom), 1'($urandom), 4'd7);
      end
      6'h04: qpush(6'($urandom), 1'($urandom), 4'd8);
      6'h08: begin
        qpush(6'($urandom), 1'($urandom), 4'd9);
        qpush(6'($urandom), 1'($urandom), 4'd10);
      end
      default: qpush(6'($urandom), 1'($urandom), 4'd11);
    endcase
  endtask

  logic [5:0] legal [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

  initial begin
    int irw_cnt, rw_cnt;
    logic [3:0] rw_state;
    logic [31:0] mcyc, minst;

    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;

    // Directed table: addi, R, lw, sw, beq, j with mem_ready held high
    add(6'h08, 1, 0); add(6'h08, 1, 1); add(6'h08, 1, 9);  add(6'h08, 1, 10);
    add(6'h00, 1, 0); add(6'h00, 1, 1); add(6'h00, 1, 6);  add(6'h00, 1, 7);
    add(6'h23, 1, 0); add(6'h23, 1, 1); add(6'h23, 1, 2);  add(6'h23, 1, 3); add(6'h23, 1, 4);
    add(6'h2B, 1, 0); add(6'h2B, 1, 1); add(6'h2B, 1, 2);  add(6'h2B, 1, 5);
    add(6'h04, 1, 0); add(6'h04, 1, 1); add(6'h04, 1, 8);
    add(6'h02, 1, 0); add(6'h02, 1, 1); add(6'h02, 1, 11);

    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].op, tbl[k].mr);
      chk($sformatf("tbl%0d_state", k), {28'd0, state}, {28'd0, tbl[k].st});
      chk($sformatf("tbl%0d_outs", k), {15'd0, act_out}, {15'd0, exp_out(tbl[k].st, tbl[k].mr, 1'b1)});
    end
    drive(6'h00, 1'b0);
    chk("seq_cycle", cycle_count, 32'd23);
    chk("seq_instr", instr_count, 32'd6);
    chk("seq_state", {28'd0, state}, 32'd0);

    // lw with 2 FETCH waits and 3 MEMRD waits
    do_reset();
    irw_cnt = 0; rw_cnt = 0; rw_state = 4'd0;
    q.delete();
    qpush(6'h23, 0, 0); qpush(6'h23, 0, 0); qpush(6'h23, 1, 0); qpush(6'h23, 1, 1);
    qpush(6'h23, 1, 2); qpush(6'h23, 0, 3); qpush(6'h23, 0, 3); qpush(6'h23, 0, 3);
    qpush(6'h23, 1, 3); qpush(6'h23, 1, 4);
    for (int k = 0; k < q.size(); k++) begin
      drive(q[k].op, q[k].mr);
      chk($sformatf("lwst%0d_state", k), {28'd0, state}, {28'd0, q[k].st});
      if (ir_write) irw_cnt++;
      if (reg_write) begin rw_cnt++; rw_state = state; end
    end
    drive(6'h00, 1'b0);
    chk("lwst_irw_pulses", irw_cnt, 32'd1);
    chk("lwst_rw_pulses", rw_cnt, 32'd1);
    chk("lwst_rw_state", {28'd0, rw_state}, 32'd4);
    chk("lwst_cycle", cycle_count, 32'd10);
    chk("lwst_instr", instr_count, 32'd1);

    // Illegal opcode halts and freezes counters
    do_reset();
    drive(6'h3F, 1'b1);
    drive(6'h3F, 1'b1);
    chk("err_decode", {28'd0, state}, 32'd1);
    drive(6'h3F, 1'b1);
    chk("err_state", {28'd0, state}, 32'd15);
    chk("err_halted", {31'd0, halted}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      drive(6'($urandom), 1'($urandom));
      chk("err_hold_outs", {15'd0, act_out}, {15'd0, exp_out(4'd15, mem_ready, 1'b1)});
      chk("err_hold_cycle", cycle_count, 32'd2);
      chk("err_hold_instr", instr_count, 32'd0);
    end
    do_reset();
    drive(6'h00, 1'b0);
    chk("err_recover", {28'd0, state}, 32'd0);

    // Asynchronous reset in the middle of a stalled store
    do_reset();
    drive(6'h2B, 1'b1);
    drive(6'h2B, 1'b1);
    drive(6'h2B, 1'b1);
    drive(6'h2B, 1'b0);
    chk("abort_pre_state", {28'd0, state}, 32'd5);
    chk("abort_pre_mw", {31'd0, mem_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mw", {31'd0, mem_write}, 32'd0);
    chk("abort_state", {28'd0, state}, 32'd0);
    chk("abort_instr", instr_count, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Cycle counter wrap
    do_reset();
    drive(6'h00, 1'b0);
    force dut.r_cycle_count = 32'hFFFF_FFFE;
    #1 release dut.r_cycle_count;
    drive(6'h00, 1'b0);
    chk("wrap_1", cycle_count, 32'hFFFF_FFFF);
    drive(6'h00, 1'b0);
    chk("wrap_2", cycle_count, 32'h0000_0000);

    // FETCH strobes follow mem_ready within the cycle
    mem_ready = 1'b0; #1;
    chk("tog0", {29'd0, pc_write, ir_write, mem_read}, 32'b001);
    mem_ready = 1'b1; #1;
    chk("tog1", {29'd0, pc_write, ir_write, mem_read}, 32'b111);
    mem_ready = 1'b0; #1;
    chk("tog2", {29'd0, pc_write, ir_write, mem_read}, 32'b001);

    // Randomized instruction stream
    do_reset();
    mcyc = 0; minst = 0;
    for (int i = 0; i < 40; i++) begin
      build_instr(legal[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));
      for (int k = 0; k < q.size(); k++) begin
        drive(q[k].op, q[k].mr);
        chk($sformatf("rnd%0d_state", i), {28'd0, state}, {28'd0, q[k].st});
        chk($sformatf("rnd%0d_outs", i), {15'd0, act_out}, {15'd0, exp_out(q[k].st, q[k].mr, 1'b1)});
        chk($sformatf("rnd%0d_cycle", i), cycle_count, mcyc);
        chk($sformatf("rnd%0d_instr", i), instr_count, minst);
        mcyc++;
      end
      minst++;
    end
    drive(6'h00, 1'b0);
    chk("rnd_final_cycle", cycle_count, mcyc);
    chk("rnd_final_instr", instr_count, minst);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multicycle control unit that sequences the shared MIPS datapath (single ALU, single unified memory port, instruction register, register file) through fetch, decode, execute, memory and write-back steps. It replaces the single-cycle combinational control and emits Moore-style control strokes per state. It waits on a memory ready handshake, halts on an illegal opcode, and keeps cycle and retired-instruction counters for the testbench.

## Interface
- No parameters; state encoding is fixed at 4 bits.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; sampled only in DECODE
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded (to ALU_CU)
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state, for debug
- halted  out  1  high in ERR
- cycle_count  out  32  cycles since reset while not halted
- instr_count  out  32  retired instructions

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERR=15. Codes 12-14 unreachable; if entered, go to ERR.
- Opcodes: R=6'h00, lw=6'h23, sw=6'h2B, beq=6'h04, addi=6'h08, j=6'h02. Any other goes to ERR.
- Transitions: FETCH->DECODE on mem_ready, else hold. DECODE->MEMADR (lw/sw), EXEC (R), BRANCH (beq), ADDIEX (addi), JUMP (j), ERR (other). MEMADR->MEMRD (lw) / MEMWR (sw); opcode is re-read, and the IR is stable. MEMRD->MEMWB on mem_ready, else hold. MEMWR->FETCH on mem_ready, else hold. EXEC->RTYPEWB. ADDIEX->ADDIWB. MEMWB, RTYPEWB, BRANCH, ADDIWB, JUMP->FETCH. ERR holds until rst_n is low.
- Outputs asserted per state; all others are 0:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_read=1, iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEMWR: mem_write=1, iord=1, held until mem_ready.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - JUMP: pc_write=1, pc_source=10.
  - ERR: halted=1.
- Write strobes (pc_write, pc_write_cond, ir_write, reg_write, mem_write) are ANDed with rst_n.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTYPEWB, BRANCH, ADDIWB or JUMP. It does not increment on entry to ERR.
- cycle_count increments every clock while state!=ERR.
- Both counters wrap from 32'hFFFFFFFF to 0.

## Timing
- Reset (async, rst_n=0): state=FETCH, counters=0, halted=0, and all write strobes are 0. Non-strobe outputs show the FETCH values.
- The first rising edge after rst_n goes high evaluates FETCH.
- Cycle counts with mem_ready held at 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each low cycle of mem_ready in FETCH, MEMRD or MEMWR adds one cycle. Strobes that depend on mem_ready stay 0 during a wait.
- Outputs depend on state and mem_ready only, never on opcode. Opcode affects only the next state.
- Reset asserted mid-instruction aborts it immediately. No retire is counted, and strobes drop in the same cycle.

## Test plan
- Reset, then the sequence addi/R/lw/sw/beq/j with mem_ready=1 -> state traces 0,1,9,10 / 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,11; after 23 cycles instr_count=6 and cycle_count=23.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> instruction takes 10 cycles; ir_write pulses exactly once; reg_write pulses once, in MEMWB.
- Opcode 6'h3F in DECODE -> ERR next cycle, halted=1; counters freeze; all strobes stay 0 for 20 cycles; rst_n pulse returns state to 0.
- rst_n dropped asynchronously mid-MEMWR with mem_write=1 -> mem_write falls within the same cycle; state=0; instr_count is unchanged from its pre-instruction value (0 after reset).
- cycle_count preloaded (via force) to 32'hFFFFFFFE -> after 2 cycles it reads 32'h00000000.
- In FETCH, mem_ready toggling 0,1 -> pc_write and ir_write follow mem_ready combinationally; mem_read stays 1 throughout.
